// File: rtl/core_pkg.sv
// Shared opcodes, instruction field positions and state/class encodings for the core sequencer.
package core_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ALU   = 6'h01;
    localparam logic [5:0] OP_LOAD  = 6'h02;
    localparam logic [5:0] OP_STORE = 6'h03;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_ALU   = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STORE = 3'd3,
        CL_HALT  = 3'd4
    } op_class_e;

endpackage

// File: rtl/core_controller_instr_decode.sv
// Combinational instruction decode: opcode class, register-write flag and register addresses.
module instr_decode
    import core_pkg::*;
#(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
) (
    input  logic [DataSize-1:0] ir,
    output op_class_e           op_class,
    output logic                writes_reg,
    output logic [AddrSize-1:0] rs1_addr,
    output logic [AddrSize-1:0] rs2_addr,
    output logic [AddrSize-1:0] rd_addr
);

    logic unused_low_bits;
    assign unused_low_bits = ^ir[RS2_LSB-1:0];

    assign rd_addr  = ir[RD_LSB  +: AddrSize];
    assign rs1_addr = ir[RS1_LSB +: AddrSize];
    assign rs2_addr = ir[RS2_LSB +: AddrSize];

    // Unknown opcodes fall into the NOP class.
    always_comb begin
        op_class = CL_NOP;
        case (ir[OPC_MSB:OPC_LSB])
            OP_NOP:   op_class = CL_NOP;
            OP_ALU:   op_class = CL_ALU;
            OP_LOAD:  op_class = CL_LOAD;
            OP_STORE: op_class = CL_STORE;
            OP_HALT:  op_class = CL_HALT;
            default:  op_class = CL_NOP;
        endcase
    end

    assign writes_reg = (op_class == CL_ALU) || (op_class == CL_LOAD);

endmodule

// File: rtl/core_controller.sv
// Multi-cycle fetch/decode/execute sequencer owning the PC and per-instruction FSM.
// Define CORE_CONTROLLER_MEM_TIMEOUT_EN to add a 16-cycle data-memory timeout with mem_fault.
module core_controller
    import core_pkg::*;
#(
    parameter int                  DataSize = 32,
    parameter int                  AddrSize = 5,
    parameter logic [DataSize-1:0] PcReset  = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DataSize-1:0] instruction,
    input  logic                im_ready,
    input  logic                dm_ready,
    output logic [DataSize-1:0] pc,
    output logic                do_im_fetch,
    output logic                do_reg_fetch,
    output logic                do_execute,
    output logic                do_dm_read,
    output logic                do_dm_write,
    output logic                do_reg_write,
    output logic                enable_reg_write,
    output logic [AddrSize-1:0] read_reg_addr1,
    output logic [AddrSize-1:0] read_reg_addr2,
    output logic [AddrSize-1:0] write_address,
    output logic                halted
`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
    ,
    output logic                mem_fault
`endif
);

    localparam logic [DataSize-1:0] PC_STEP = DataSize'(32'd4);

    state_e              state_q, state_d;
    logic [DataSize-1:0] pc_q, pc_d;
    logic [DataSize-1:0] ir_q, ir_d;
    logic                fetch_take;
    logic                im_fetch_q, im_fetch_d;
    logic                reg_fetch_q, reg_fetch_d;
    logic                execute_q, execute_d;
    logic                dm_read_q, dm_read_d;
    logic                dm_write_q, dm_write_d;
    logic                reg_write_q, reg_write_d;
    logic                wr_en_q, wr_en_d;
    logic                halted_q, halted_d;
    logic [AddrSize-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

    op_class_e           op_class;
    logic                writes_reg;
    logic [AddrSize-1:0] dec_rs1, dec_rs2, dec_rd;

`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
    logic [3:0]          tmo_cnt_q, tmo_cnt_d;
    logic                mem_fault_q, mem_fault_d;
`endif

    // A fetch only completes once the request strobe is actually visible outside.
    assign fetch_take = (state_q == ST_FETCH) && im_fetch_q && im_ready;
    assign ir_d       = fetch_take ? instruction : ir_q;

    instr_decode #(
        .DataSize (DataSize),
        .AddrSize (AddrSize)
    ) u_decode (
        .ir         (ir_d),
        .op_class   (op_class),
        .writes_reg (writes_reg),
        .rs1_addr   (dec_rs1),
        .rs2_addr   (dec_rs2),
        .rd_addr    (dec_rd)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
        tmo_cnt_d   = 4'd0;
        mem_fault_d = mem_fault_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (fetch_take) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (op_class == CL_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_class)
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_ALU:            state_d = ST_WB;
                    default: begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + PC_STEP;
                    end
                endcase
            end
            ST_MEM: begin
                if (dm_ready) begin
                    if (op_class == CL_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + PC_STEP;
                    end
                end else begin
                    state_d = ST_MEM;
`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
                    // Sixteenth silent MEM cycle gives up and parks the core.
                    if (tmo_cnt_q == 4'hF) begin
                        state_d     = ST_HALT;
                        mem_fault_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 4'd1;
                    end
`endif
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + PC_STEP;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes are decoded from the next state so they register in step with it.
    always_comb begin
        im_fetch_d  = (state_d == ST_FETCH);
        reg_fetch_d = (state_d == ST_DECODE);
        execute_d   = (state_d == ST_EXEC);
        dm_read_d   = (state_d == ST_MEM) && (op_class == CL_LOAD);
        dm_write_d  = (state_d == ST_MEM) && (op_class == CL_STORE);
        reg_write_d = (state_d == ST_WB);
        halted_d    = (state_d == ST_HALT);
        wr_en_d     = writes_reg && (state_d inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB});
        rs1_d       = dec_rs1;
        rs2_d       = dec_rs2;
        rd_d        = dec_rd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= PcReset;
            ir_q        <= {DataSize{1'b0}};
            im_fetch_q  <= 1'b0;
            reg_fetch_q <= 1'b0;
            execute_q   <= 1'b0;
            dm_read_q   <= 1'b0;
            dm_write_q  <= 1'b0;
            reg_write_q <= 1'b0;
            wr_en_q     <= 1'b0;
            halted_q    <= 1'b0;
            rs1_q       <= {AddrSize{1'b0}};
            rs2_q       <= {AddrSize{1'b0}};
            rd_q        <= {AddrSize{1'b0}};
`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
            tmo_cnt_q   <= 4'd0;
            mem_fault_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            im_fetch_q  <= im_fetch_d;
            reg_fetch_q <= reg_fetch_d;
            execute_q   <= execute_d;
            dm_read_q   <= dm_read_d;
            dm_write_q  <= dm_write_d;
            reg_write_q <= reg_write_d;
            wr_en_q     <= wr_en_d;
            halted_q    <= halted_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            mem_fault_q <= mem_fault_d;
`endif
        end
    end

    assign pc               = pc_q;
    assign do_im_fetch      = im_fetch_q;
    assign do_reg_fetch     = reg_fetch_q;
    assign do_execute       = execute_q;
    assign do_dm_read       = dm_read_q;
    assign do_dm_write      = dm_write_q;
    assign do_reg_write     = reg_write_q;
    assign enable_reg_write = wr_en_q;
    assign read_reg_addr1   = rs1_q;
    assign read_reg_addr2   = rs2_q;
    assign write_address    = rd_q;
    assign halted           = halted_q;
`ifdef CORE_CONTROLLER_MEM_TIMEOUT_EN
    assign mem_fault        = mem_fault_q;
`endif

endmodule

// File: doc/core_controller.md
# core_controller

Multi-cycle sequencer that fetches one instruction at a time, decodes its register fields, and drives the register file's strobes (`do_reg_fetch`, `do_reg_write`, `enable_reg_write`) and addresses. It sits directly upstream of the register file and alongside the ALU and data-memory port. It owns the PC and the per-instruction state machine. The ALU and memory datapath are external; this block only sequences them.

## Interface
- `DataSize`, 32: instruction and PC width.
- `AddrSize`, 5: register address width.
- `PcReset`, 32'h0000_0000: PC value on reset.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `instruction`  in  DataSize: instruction word, valid when `im_ready`=1.
- `im_ready`  in  1: instruction memory returns `instruction` this cycle.
- `dm_ready`  in  1: data memory completes a read or write this cycle.
- `pc`  out  DataSize: current fetch address.
- `do_im_fetch`  out  1: instruction read request.
- `do_reg_fetch`  out  1: register read strobe.
- `do_execute`  out  1: ALU evaluate strobe.
- `do_dm_read` / `do_dm_write`  out  1: data memory request.
- `do_reg_write`  out  1: writeback phase.
- `enable_reg_write`  out  1: instruction writes a register.
- `read_reg_addr1`, `read_reg_addr2`, `write_address`  out  AddrSize: register addresses.
- `halted`  out  1: HALT retired.
- `mem_fault`  out  1: data-memory timeout. Present only with the macro.

## Operation
- Instruction fields: opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11].
- Opcodes:
  - 6'h00 NOP
  - 6'h01 ALU (writes rd)
  - 6'h02 LOAD (writes rd)
  - 6'h03 STORE (no write)
  - 6'h3F HALT
  - Any other opcode is treated as NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Assert `do_im_fetch`; hold until `im_ready`.
  - On `im_ready`, latch `instruction` into the IR and go to DECODE.
- DECODE:
  - Assert `do_reg_fetch` for exactly 1 cycle.
  - Addresses come from IR fields, held stable from DECODE through WB.
  - Next state: HALT if the opcode is HALT, otherwise EXEC.
- EXEC:
  - Assert `do_execute` for 1 cycle.
  - LOAD or STORE goes to MEM; ALU goes to WB; NOP goes to FETCH with PC+4.
- MEM:
  - Assert `do_dm_read` (LOAD) or `do_dm_write` (STORE) until `dm_ready`.
  - On `dm_ready`: LOAD goes to WB; STORE goes to FETCH with PC+4.
- WB:
  - Assert `do_reg_write` for 1 cycle, with `enable_reg_write`=1 and `write_address`=rd.
  - Then go to FETCH with PC+4.
- `enable_reg_write` is 1 from DECODE through WB for ALU and LOAD; it is 0 otherwise.
- `write_address`=0 is legal; the register file decides whether r0 is writable.
- HALT: terminal. `halted`=1, all strobes 0. Only reset leaves it.
- PC arithmetic: modulo 2^DataSize, so 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (`reset`=0, asynchronous):
  - State=FETCH, `pc`=PcReset, IR=0.
  - All strobes, addresses, `halted` and `mem_fault` = 0.
- Reset mid-instruction aborts it. No writeback or memory strobe may appear after reset asserts.
- First `do_im_fetch` is in the first cycle after reset deasserts.
- `im_ready` in that same cycle completes the fetch.
- Strobes are registered state decodes. They are mutually exclusive: at most one `do_*` is high per cycle.
- Latency in cycles, with zero wait states, from fetch through retire:
  - NOP 3
  - ALU 4
  - STORE 4
  - LOAD 5
  - Each wait cycle on `im_ready` or `dm_ready` adds 1.
- `pc` updates on the edge leaving the retiring state and is stable otherwise.
- `im_ready` or `dm_ready` arriving outside FETCH or MEM is ignored.

## Configuration
- Macro: `CORE_CONTROLLER_MEM_TIMEOUT_EN`.
- Defined:
  - A 4-bit counter runs in MEM and clears on entry.
  - If `dm_ready` is still 0 after 16 MEM cycles, set `mem_fault`=1 (sticky until reset) and go to HALT. `halted` is also 1 in this case.
- Undefined:
  - No `mem_fault` port and no counter.
  - MEM waits indefinitely.

## Structure
- Shared package `core_pkg`:
  - Opcode constants (OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_HALT).
  - State encoding constants.
  - Field bit positions.
- Sub-module `instr_decode`: combinational mapping of IR to opcode class, `enable_reg_write` and the three addresses.
- The FSM, PC and timeout counter stay in `core_controller`.

## Test plan
- Reset, then ALU 32'h0422_1800 (rd=1, rs1=2, rs2=3) with `im_ready` constant 1 -> `do_reg_fetch` in cycle 2 with addr1=2 and addr2=3; `do_reg_write` in cycle 4 with `write_address`=1; `pc`=4.
- LOAD with `dm_ready` delayed 3 cycles -> `do_dm_read` high for 4 cycles, then `do_reg_write` 1 cycle; total 8 cycles; `pc`=4.
- STORE then NOP -> `enable_reg_write` never 1 and `do_reg_write` never 1; `pc`=8 after 7 cycles.
- HALT 32'hFC00_0000 -> `halted`=1 after DECODE; no further `do_im_fetch` for 20 cycles; `pc` frozen.
- `reset` asserted in the MEM cycle of a LOAD -> outputs zero immediately; no `do_reg_write`; refetch from PcReset.
- With `CORE_CONTROLLER_MEM_TIMEOUT_EN` and `dm_ready` held at 0 -> `mem_fault`=1 and `halted`=1 after 16 MEM cycles. Without the macro -> still in MEM after 100 cycles.
